timer_sched: RTL and testbench

- Multi-channel one-shot deadline scheduler built around one shared prescaled tick.
- Lets several software tasks share a single hardware timebase instead of each owning a timer CSR.
- Each channel is armed with a relative delay and raises a per-channel pending bit on expiry.
- A sequential scanner publishes the channel with the nearest expiry for the interrupt/dispatch logic.

---
 rtl/timer_sched.sv | 193 +++++++++++++++++++
 tb/tb_timer_sched.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// timer_sched: multi-channel one-shot deadline scheduler sharing one prescaled tick.
// Optional periodic reload per channel is enabled with `define TIMER_SCHED_PERIODIC_EN.
module timer_sched #(
  parameter int NumChannels    = 4,
  parameter int DelayWidth     = 16,
  parameter int PrescalerWidth = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [PrescalerWidth-1:0]      prescaler,
  input  logic                           cfg_we,
  input  logic [$clog2(NumChannels)-1:0] cfg_ch,
  input  logic                           cfg_arm,
  input  logic [DelayWidth-1:0]          cfg_delay,
`ifdef TIMER_SCHED_PERIODIC_EN
  input  logic                           cfg_periodic,
`endif
  input  logic [NumChannels-1:0]         pending_clear,
  output logic [NumChannels-1:0]         pending,
  output logic [NumChannels-1:0]         armed,
  output logic                           irq,
  output logic [$clog2(NumChannels)-1:0] next_ch,
  output logic                           next_valid,
  output logic                           tick
);

  localparam int ChW  = $clog2(NumChannels);
  localparam int CntW = 2 ** PrescalerWidth;

  typedef enum logic {
    IDLE,
    SCAN
  } scan_state_t;

  logic [CntW-1:0]       pre_cnt;
  logic [CntW-1:0]       tick_limit;

  logic [DelayWidth-1:0] remaining [NumChannels];
  logic [NumChannels-1:0] cfg_hit;
  logic [NumChannels-1:0] expire;

`ifdef TIMER_SCHED_PERIODIC_EN
  logic [DelayWidth-1:0]  period [NumChannels];
  logic [NumChannels-1:0] periodic;
`endif

  scan_state_t           state_q, state_d;
  logic [ChW-1:0]        scan_idx_q, scan_idx_d;
  logic [DelayWidth-1:0] best_rem_q, best_rem_d;
  logic [ChW-1:0]        best_ch_q, best_ch_d;
  logic                  found_q, found_d;
  logic [ChW-1:0]        next_ch_d;
  logic                  next_valid_d;
  logic                  take;
  logic [DelayWidth-1:0] cur_rem;

  // The >= compare lets a lowered prescaler fire on the next cycle instead of wrapping.
  assign tick_limit = (CntW'(1) << prescaler) - CntW'(1);
  assign tick       = enable && !reset && (pre_cnt >= tick_limit);
  assign irq        = |pending;

  always_ff @(posedge clk) begin
    if (reset || !enable || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + CntW'(1);
    end
  end

  always_comb begin
    cfg_hit = '0;
    expire  = '0;
    for (int i = 0; i < NumChannels; i++) begin
      cfg_hit[i] = cfg_we && (cfg_ch == ChW'(i));
      expire[i]  = !cfg_hit[i] && tick && armed[i] && (remaining[i] <= DelayWidth'(1));
    end
  end

  // A configuration write takes priority over a tick landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      armed   <= '0;
      for (int i = 0; i < NumChannels; i++) begin
        remaining[i] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
        period[i]    <= '0;
`endif
      end
`ifdef TIMER_SCHED_PERIODIC_EN
      periodic <= '0;
`endif
    end else begin
      pending <= expire | (pending & ~pending_clear);
      for (int i = 0; i < NumChannels; i++) begin
        if (cfg_hit[i]) begin
          if (cfg_arm) begin
            remaining[i] <= cfg_delay;
            armed[i]     <= 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
            period[i]    <= cfg_delay;
            periodic[i]  <= cfg_periodic;
`endif
          end else begin
            remaining[i] <= '0;
            armed[i]     <= 1'b0;
`ifdef TIMER_SCHED_PERIODIC_EN
            periodic[i]  <= 1'b0;
`endif
          end
        end else if (expire[i]) begin
`ifdef TIMER_SCHED_PERIODIC_EN
          if (periodic[i]) begin
            remaining[i] <= (period[i] == '0) ? DelayWidth'(1) : period[i];
          end else begin
            remaining[i] <= '0;
            armed[i]     <= 1'b0;
          end
`else
          remaining[i] <= '0;
          armed[i]     <= 1'b0;
`endif
        end else if (tick && armed[i]) begin
          remaining[i] <= remaining[i] - DelayWidth'(1);
        end
      end
    end
  end

  // Scanner: one channel per cycle; ties keep the lower index because only a strictly
  // smaller remaining count replaces the current best.
  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    best_rem_d   = best_rem_q;
    best_ch_d    = best_ch_q;
    found_d      = found_q;
    next_ch_d    = next_ch;
    next_valid_d = next_valid;
    take         = 1'b0;
    cur_rem      = remaining[scan_idx_q];
    case (state_q)
      IDLE: begin
        state_d    = SCAN;
        scan_idx_d = '0;
        found_d    = 1'b0;
      end
      SCAN: begin
        take = armed[scan_idx_q] && (!found_q || (cur_rem < best_rem_q));
        if (take) begin
          best_rem_d = cur_rem;
          best_ch_d  = scan_idx_q;
          found_d    = 1'b1;
        end
        if (scan_idx_q == ChW'(NumChannels - 1)) begin
          next_valid_d = found_q || take;
          if (found_q || take) begin
            next_ch_d = take ? scan_idx_q : best_ch_q;
          end
          scan_idx_d = '0;
          found_d    = 1'b0;
        end else begin
          scan_idx_d = scan_idx_q + ChW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      scan_idx_q <= '0;
      best_rem_q <= '0;
      best_ch_q  <= '0;
      found_q    <= 1'b0;
      next_ch    <= '0;
      next_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      best_rem_q <= best_rem_d;
      best_ch_q  <= best_ch_d;
      found_q    <= found_d;
      next_ch    <= next_ch_d;
      next_valid <= next_valid_d;
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: scoreboard bench for timer_sched; a tick-level reference model
// pushes the expected per-cycle outputs and a negedge monitor compares them.
module tb_timer_sched;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int PW = 4;

  typedef struct {
    logic          rst;
    logic          en;
    logic [PW-1:0] presc;
    logic          we;
    logic [1:0]    ch;
    logic          arm;
    logic [DW-1:0] delay;
    logic [N-1:0]  clr;
    logic          per;
  } stim_t;

  typedef struct {
    logic         tk;
    logic [N-1:0] pend;
    logic [N-1:0] arm;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [PW-1:0] prescaler = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic          cfg_arm = 1'b0;
  logic [DW-1:0] cfg_delay = '0;
`ifdef TIMER_SCHED_PERIODIC_EN
  logic          cfg_periodic = 1'b0;
`endif
  logic [N-1:0]  pending_clear = '0;
  logic [N-1:0]  pending;
  logic [N-1:0]  armed;
  logic          irq;
  logic [1:0]    next_ch;
  logic          next_valid;
  logic          tick;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];

  // Reference model: tick counter, per-channel remaining ticks and flags.
  int           mcnt;
  int           mrem [N];
  int           mper [N];
  logic [N-1:0] marmed;
  logic [N-1:0] mpend;
  logic [N-1:0] mperiodic;
  bit           mvalid = 1'b0;

  logic          en_r = 1'b1;
  logic [PW-1:0] presc_r = '0;

  always #5 clk = ~clk;

  timer_sched #(
    .NumChannels(N),
    .DelayWidth(DW),
    .PrescalerWidth(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .prescaler(prescaler),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_arm(cfg_arm),
    .cfg_delay(cfg_delay),
`ifdef TIMER_SCHED_PERIODIC_EN
    .cfg_periodic(cfg_periodic),
`endif
    .pending_clear(pending_clear),
    .pending(pending),
    .armed(armed),
    .irq(irq),
    .next_ch(next_ch),
    .next_valid(next_valid),
    .tick(tick)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic stim_t base();
    stim_t s;
    s.rst   = 1'b0;
    s.en    = en_r;
    s.presc = presc_r;
    s.we    = 1'b0;
    s.ch    = '0;
    s.arm   = 1'b0;
    s.delay = '0;
    s.clr   = '0;
    s.per   = 1'b0;
    return s;
  endfunction

  // Drives one cycle of stimulus, pushes the expected outputs for that cycle and
  // advances the model to the state visible in the following cycle.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    logic t;
    logic hit;
    @(posedge clk);
    #1;
    reset         = s.rst;
    enable        = s.en;
    prescaler     = s.presc;
    cfg_we        = s.we;
    cfg_ch        = s.ch;
    cfg_arm       = s.arm;
    cfg_delay     = s.delay;
    pending_clear = s.clr;
`ifdef TIMER_SCHED_PERIODIC_EN
    cfg_periodic  = s.per;
`endif
    if (s.rst) begin
      if (mvalid) begin
        e.tk   = 1'b0;
        e.pend = mpend;
        e.arm  = marmed;
        sb.push_back(e);
      end
      mcnt      = 0;
      marmed    = '0;
      mpend     = '0;
      mperiodic = '0;
      for (int i = 0; i < N; i++) begin
        mrem[i] = 0;
        mper[i] = 0;
      end
      mvalid = 1'b1;
      return;
    end
    if (!mvalid) return;
    t      = s.en && (mcnt >= (1 << s.presc) - 1);
    e.tk   = t;
    e.pend = mpend;
    e.arm  = marmed;
    sb.push_back(e);
    mcnt = (s.en && !t) ? mcnt + 1 : 0;
    for (int i = 0; i < N; i++) begin
      hit = s.we && (int'(s.ch) == i);
      if (hit) begin
        if (s.arm) begin
          marmed[i] = 1'b1;
          mrem[i]   = int'(s.delay);
          mper[i]   = int'(s.delay);
`ifdef TIMER_SCHED_PERIODIC_EN
          mperiodic[i] = s.per;
`endif
        end else begin
          marmed[i]    = 1'b0;
          mrem[i]      = 0;
          mperiodic[i] = 1'b0;
        end
        if (s.clr[i]) mpend[i] = 1'b0;
      end else if (t && marmed[i] && mrem[i] <= 1) begin
        mpend[i] = 1'b1;
        if (mperiodic[i]) begin
          mrem[i] = (mper[i] == 0) ? 1 : mper[i];
        end else begin
          marmed[i] = 1'b0;
          mrem[i]   = 0;
        end
      end else begin
        if (t && marmed[i]) mrem[i] = mrem[i] - 1;
        if (s.clr[i]) mpend[i] = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(base());
  endtask

  task automatic writeCfg(input int ch, input logic arm, input int delay, input logic per);
    stim_t s;
    s       = base();
    s.we    = 1'b1;
    s.ch    = 2'(ch);
    s.arm   = arm;
    s.delay = DW'(delay);
    s.per   = per;
    applyStimulus(s);
  endtask

  task automatic clearPend(input logic [N-1:0] mask);
    stim_t s;
    s     = base();
    s.clr = mask;
    applyStimulus(s);
  endtask

  task automatic doReset();
    stim_t s;
    s     = base();
    s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
  endtask

  // Freezes ticks long enough for a full scan pass, then compares against the model's minimum.
  task automatic scanCheck();
    int best;
    int bch;
    bit found;
    en_r = 1'b0;
    idle(2 * N + 2);
    found = 1'b0;
    best  = 0;
    bch   = 0;
    for (int i = 0; i < N; i++) begin
      if (marmed[i] && (!found || mrem[i] < best)) begin
        found = 1'b1;
        best  = mrem[i];
        bch   = i;
      end
    end
    @(negedge clk);
    checkOutput("scan_next_valid", 32'(next_valid), 32'(found));
    if (found) checkOutput("scan_next_ch", 32'(next_ch), 32'(bch));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("tick", 32'(tick), 32'(e.tk));
        checkOutput("pending", 32'(pending), 32'(e.pend));
        checkOutput("armed", 32'(armed), 32'(e.arm));
        checkOutput("irq", 32'(irq), 32'(|e.pend));
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    en_r    = 1'b1;
    presc_r = '0;
    doReset();
    @(negedge clk);
    checkOutput("reset_pending", 32'(pending), 32'h0);
    checkOutput("reset_armed", 32'(armed), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    checkOutput("reset_next_valid", 32'(next_valid), 32'h0);
    checkOutput("reset_next_ch", 32'(next_ch), 32'h0);
    checkOutput("reset_tick", 32'(tick), 32'h0);

    // Tick every cycle, ch1 delay 5.
    writeCfg(1, 1'b1, 5, 1'b0);
    idle(5);
    @(negedge clk);
    checkOutput("t1_pending_early", 32'(pending), 32'h0);
    idle(1);
    @(negedge clk);
    checkOutput("t1_pending", 32'(pending), 32'h2);
    checkOutput("t1_irq", 32'(irq), 32'h1);
    checkOutput("t1_armed", 32'(armed), 32'h0);
    clearPend(4'b0010);

    // Prescaler 2, ch0 delay 3.
    presc_r = 4'd2;
    writeCfg(0, 1'b1, 3, 1'b0);
    idle(16);
    @(negedge clk);
    checkOutput("t2_pending", 32'(pending), 32'h1);
    clearPend(4'b0001);
    idle(1);
    @(negedge clk);
    checkOutput("t2_cleared", 32'(pending), 32'h0);

    // Nearest-deadline scan with ticks frozen.
    en_r = 1'b0;
    writeCfg(0, 1'b1, 10, 1'b0);
    writeCfg(2, 1'b1, 4, 1'b0);
    writeCfg(3, 1'b1, 4, 1'b0);
    idle(2 * N + 2);
    @(negedge clk);
    checkOutput("t3_valid", 32'(next_valid), 32'h1);
    checkOutput("t3_ch_tie", 32'(next_ch), 32'h2);
    writeCfg(2, 1'b0, 0, 1'b0);
    idle(2 * N + 2);
    @(negedge clk);
    checkOutput("t3_ch_after_cancel", 32'(next_ch), 32'h3);
    writeCfg(0, 1'b0, 0, 1'b0);
    writeCfg(3, 1'b0, 0, 1'b0);
    idle(2 * N + 2);
    @(negedge clk);
    checkOutput("t3_none_valid", 32'(next_valid), 32'h0);
    checkOutput("t3_none_hold", 32'(next_ch), 32'h3);

    // Re-arm in the expiring tick cycle, then set-beats-clear.
    en_r    = 1'b1;
    presc_r = '0;
    writeCfg(1, 1'b1, 2, 1'b0);
    idle(1);
    writeCfg(1, 1'b1, 7, 1'b0);
    idle(1);
    @(negedge clk);
    checkOutput("t4_no_pend_rearm", 32'(pending[1]), 32'h0);
    idle(6);
    @(negedge clk);
    checkOutput("t4_not_yet", 32'(pending[1]), 32'h0);
    idle(1);
    @(negedge clk);
    checkOutput("t4_expired", 32'(pending[1]), 32'h1);
    writeCfg(1, 1'b1, 1, 1'b0);
    clearPend(4'b0010);
    idle(1);
    @(negedge clk);
    checkOutput("t4_set_wins", 32'(pending[1]), 32'h1);
    clearPend(4'b0010);

    // Delay 0 at prescaler 3, then enable low freezes the countdown.
    presc_r = 4'd3;
    writeCfg(2, 1'b1, 0, 1'b0);
    idle(8);
    @(negedge clk);
    checkOutput("t5_delay0", 32'(pending[2]), 32'h1);
    clearPend(4'b0100);
    writeCfg(0, 1'b1, 2, 1'b0);
    en_r = 1'b0;
    idle(20);
    @(negedge clk);
    checkOutput("t5_frozen_armed", 32'(armed[0]), 32'h1);
    checkOutput("t5_frozen_pend", 32'(pending[0]), 32'h0);
    en_r = 1'b1;
    idle(20);
    @(negedge clk);
    checkOutput("t5_resumed", 32'(pending[0]), 32'h1);
    clearPend(4'b0001);

`ifdef TIMER_SCHED_PERIODIC_EN
    // Periodic reload keeps the channel armed until cancelled.
    presc_r = '0;
    writeCfg(0, 1'b1, 3, 1'b1);
    idle(10);
    @(negedge clk);
    checkOutput("t6_still_armed", 32'(armed[0]), 32'h1);
    checkOutput("t6_pending", 32'(pending[0]), 32'h1);
    writeCfg(0, 1'b0, 0, 1'b0);
    clearPend(4'b0001);
    idle(10);
    @(negedge clk);
    checkOutput("t6_stopped", 32'(pending[0]), 32'h0);
`endif

    // Randomized traffic, each round followed by a frozen scan check.
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 60; c++) begin
        s       = base();
        s.rst   = ($urandom_range(0, 199) == 0);
        s.en    = ($urandom_range(0, 9) != 0);
        s.presc = PW'($urandom_range(0, 2));
        s.we    = ($urandom_range(0, 3) == 0);
        s.ch    = 2'($urandom_range(0, N - 1));
        s.arm   = ($urandom_range(0, 3) != 0);
        s.delay = ($urandom_range(0, 15) == 0) ? DW'($urandom) : DW'($urandom_range(0, 9));
        s.clr   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        s.per   = 1'($urandom_range(0, 1));
        applyStimulus(s);
      end
      scanCheck();
    end

    // Reset in the middle of activity.
    en_r    = 1'b1;
    presc_r = '0;
    writeCfg(3, 1'b1, 1, 1'b0);
    s     = base();
    s.rst = 1'b1;
    applyStimulus(s);
    idle(1);
    @(negedge clk);
    checkOutput("midreset_pending", 32'(pending), 32'h0);
    checkOutput("midreset_armed", 32'(armed), 32'h0);
    idle(3);

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("scoreboard_drain", 32'(sb.size()), 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
